// File: rtl/sound_cmd_sched.sv
// Sound command scheduler: four requesters with one pending slot each, arbitrated onto the 6-bit
// sound bus pb. Each command is held for HOLD_E E ticks, followed by GAP_E ticks of idle code.
module sound_cmd_sched #(
  parameter int HOLD_E = 8,
  parameter int GAP_E  = 4,
  parameter int RR     = 0
) (
  input  logic        clk_4e,
  input  logic        reset,
  input  logic        e_tick,
  input  logic        flush,
  input  logic [3:0]  req,
  input  logic [23:0] cmd,
  output logic [3:0]  ack,
  output logic [3:0]  issued,
  output logic [5:0]  pb,
  output logic        busy,
  output logic [1:0]  active_id
);

  localparam logic [5:0] IDLE_CODE = 6'h3F;
  localparam logic [7:0] HOLD_CNT  = 8'(HOLD_E);
  localparam logic [7:0] GAP_CNT   = 8'(GAP_E);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  state_t          state, state_nxt;
  logic [7:0]      cnt, cnt_nxt;
  logic [3:0]      slot_vld, slot_vld_nxt;
  logic [3:0][5:0] slot_code, slot_code_nxt;
  logic [3:0]      ack_pend, ack_pend_nxt;
  logic [3:0]      ack_nxt, issued_nxt;
  logic [5:0]      pb_nxt;
  logic [1:0]      id_nxt;
  logic [1:0]      last_w, last_w_nxt;
  logic            win_vld;
  logic [1:0]      win;

  // Arbiter. The loops run from lowest to highest priority, so the last hit wins.
  always_comb begin
    win_vld = |slot_vld;
    win     = 2'd0;
    if (RR == 0) begin
      for (int i = 3; i >= 0; i--) begin
        if (slot_vld[i]) win = 2'(i);
      end
    end else begin
      // Offset 4 wraps to the previous winner itself, which is searched last.
      for (int k = 4; k >= 1; k--) begin
        if (slot_vld[2'(last_w + 2'(k))]) win = 2'(last_w + 2'(k));
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    slot_vld_nxt  = slot_vld;
    slot_code_nxt = slot_code;
    ack_pend_nxt  = 4'd0;
    // The ack is delayed a cycle so that, from IDLE, it lines up with the issued pulse.
    ack_nxt       = ack_pend;
    issued_nxt    = 4'd0;
    pb_nxt        = pb;
    id_nxt        = active_id;
    last_w_nxt    = last_w;

    case (state)
      IDLE: begin
        if (win_vld) begin
          pb_nxt            = slot_code[win];
          slot_vld_nxt[win] = 1'b0;
          id_nxt            = win;
          issued_nxt[win]   = 1'b1;
          cnt_nxt           = HOLD_CNT;
          last_w_nxt        = win;
          state_nxt         = DRIVE;
        end
      end
      DRIVE: begin
        if (e_tick) begin
          if (cnt == 8'd1) begin
            pb_nxt = IDLE_CODE;
            if (GAP_E > 0) begin
              cnt_nxt   = GAP_CNT;
              state_nxt = GAP;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            cnt_nxt = cnt - 8'd1;
          end
        end
      end
      GAP: begin
        if (e_tick) begin
          if (cnt == 8'd1) state_nxt = IDLE;
          else             cnt_nxt   = cnt - 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Capture runs after the issue, so a slot re-requested as it wins stays valid with the new code.
    for (int n = 0; n < 4; n++) begin
      if (req[n]) begin
        ack_pend_nxt[n] = 1'b1;
        if (cmd[6*n +: 6] != IDLE_CODE) begin
          slot_vld_nxt[n]  = 1'b1;
          slot_code_nxt[n] = cmd[6*n +: 6];
        end
      end
    end

    if (flush) begin
      slot_vld_nxt = 4'd0;
      ack_pend_nxt = 4'd0;
      issued_nxt   = 4'd0;
      pb_nxt       = IDLE_CODE;
      id_nxt       = active_id;
      last_w_nxt   = last_w;
      state_nxt    = IDLE;
    end
  end

  always_ff @(posedge clk_4e) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      slot_vld  <= 4'd0;
      slot_code <= '0;
      ack_pend  <= 4'd0;
      ack       <= 4'd0;
      issued    <= 4'd0;
      pb        <= IDLE_CODE;
      active_id <= 2'd0;
      last_w    <= 2'd3;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      slot_vld  <= slot_vld_nxt;
      slot_code <= slot_code_nxt;
      ack_pend  <= ack_pend_nxt;
      ack       <= ack_nxt;
      issued    <= issued_nxt;
      pb        <= pb_nxt;
      active_id <= id_nxt;
      last_w    <= last_w_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sound_cmd_sched.sv
// Bench for sound_cmd_sched: a table of per-cycle vectors plus directed multi-cycle sequences
// on three instances (fixed priority, round-robin, zero gap).
module tb_sound_cmd_sched;

  logic        clk_4e = 1'b0;
  logic        reset  = 1'b1;
  logic        e_tick = 1'b0;
  logic        flush  = 1'b0;
  logic [3:0]  req    = 4'd0;
  logic [23:0] cmd    = 24'd0;

  logic [3:0] fp_ack, fp_issued, rr_ack, rr_issued, g0_ack, g0_issued;
  logic [5:0] fp_pb, rr_pb, g0_pb;
  logic       fp_busy, rr_busy, g0_busy;
  logic [1:0] fp_id, rr_id, g0_id;

  always #5 clk_4e = ~clk_4e;

  sound_cmd_sched #(.HOLD_E(8), .GAP_E(4), .RR(0)) u_fp (
    .clk_4e(clk_4e), .reset(reset), .e_tick(e_tick), .flush(flush), .req(req), .cmd(cmd),
    .ack(fp_ack), .issued(fp_issued), .pb(fp_pb), .busy(fp_busy), .active_id(fp_id));
  sound_cmd_sched #(.HOLD_E(8), .GAP_E(4), .RR(1)) u_rr (
    .clk_4e(clk_4e), .reset(reset), .e_tick(e_tick), .flush(flush), .req(req), .cmd(cmd),
    .ack(rr_ack), .issued(rr_issued), .pb(rr_pb), .busy(rr_busy), .active_id(rr_id));
  sound_cmd_sched #(.HOLD_E(8), .GAP_E(0), .RR(0)) u_g0 (
    .clk_4e(clk_4e), .reset(reset), .e_tick(e_tick), .flush(flush), .req(req), .cmd(cmd),
    .ack(g0_ack), .issued(g0_issued), .pb(g0_pb), .busy(g0_busy), .active_id(g0_id));

  typedef struct {
    logic [3:0]  req;
    logic [23:0] cmd;
    logic        flush;
    logic        tick;
    logic [3:0]  ack;
    logic [3:0]  iss;
    logic [5:0]  pb;
    logic        busy;
    logic [1:0]  id;
  } vec_t;

  vec_t tab[12];
  int   total = 0, bad = 0;
  int   cyc = 0;
  logic tick_en = 1'b0;
  int   ack0_cnt, iss_cnt, iss0_cnt, seen01;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk_4e);
    @(negedge clk_4e);
    cyc++;
    if (tick_en) e_tick = (cyc % 4 == 0);
    ack0_cnt += int'(fp_ack[0]);
    iss_cnt  += int'(fp_issued != 4'd0);
    iss0_cnt += int'(fp_issued[0]);
    seen01   += int'(fp_pb == 6'h01);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 4'd0; flush = 1'b0; cmd = 24'd0;
    step(); step();
    reset = 1'b0;
    ack0_cnt = 0; iss_cnt = 0; iss0_cnt = 0; seen01 = 0;
  endtask

  initial begin
    int ticks, extra, gapc, n;
    logic t, timeout;
    int exp_order[5];
    int got_order[5];

    tab[0]  = '{4'h0, 24'h000000, 1'b0, 1'b0, 4'h0, 4'h0, 6'h3F, 1'b0, 2'd0};
    tab[1]  = '{4'h2, 24'h000FC0, 1'b0, 1'b0, 4'h0, 4'h0, 6'h3F, 1'b0, 2'd0};
    tab[2]  = '{4'h0, 24'h000000, 1'b0, 1'b0, 4'h2, 4'h0, 6'h3F, 1'b0, 2'd0};
    tab[3]  = '{4'h0, 24'h000000, 1'b0, 1'b0, 4'h0, 4'h0, 6'h3F, 1'b0, 2'd0};
    tab[4]  = '{4'h4, 24'h005000, 1'b1, 1'b0, 4'h0, 4'h0, 6'h3F, 1'b0, 2'd0};
    tab[5]  = '{4'h0, 24'h000000, 1'b0, 1'b0, 4'h0, 4'h0, 6'h3F, 1'b0, 2'd0};
    tab[6]  = '{4'h0, 24'h000000, 1'b0, 1'b0, 4'h0, 4'h0, 6'h3F, 1'b0, 2'd0};
    tab[7]  = '{4'h8, 24'hA80000, 1'b0, 1'b0, 4'h0, 4'h0, 6'h3F, 1'b0, 2'd0};
    tab[8]  = '{4'h0, 24'h000000, 1'b0, 1'b0, 4'h8, 4'h8, 6'h2A, 1'b1, 2'd3};
    tab[9]  = '{4'h0, 24'h000000, 1'b0, 1'b1, 4'h0, 4'h0, 6'h2A, 1'b1, 2'd3};
    tab[10] = '{4'h0, 24'h000000, 1'b1, 1'b0, 4'h0, 4'h0, 6'h3F, 1'b0, 2'd0};
    tab[11] = '{4'h0, 24'h000000, 1'b0, 1'b0, 4'h0, 4'h0, 6'h3F, 1'b0, 2'd0};

    do_reset();
    chk("rst_pb", 32'(fp_pb), 32'h3F);
    chk("rst_ack", 32'(fp_ack), 32'h0);
    chk("rst_issued", 32'(fp_issued), 32'h0);
    chk("rst_busy", 32'(fp_busy), 32'h0);
    chk("rst_id", 32'(fp_id), 32'h0);

    // Table: idle-code request, flush suppression, issue, flush in DRIVE (no free-running ticks).
    for (int i = 0; i < 12; i++) begin
      req = tab[i].req; cmd = tab[i].cmd; flush = tab[i].flush; e_tick = tab[i].tick;
      step();
      chk($sformatf("tab%0d_ack", i), 32'(fp_ack), 32'(tab[i].ack));
      chk($sformatf("tab%0d_iss", i), 32'(fp_issued), 32'(tab[i].iss));
      chk($sformatf("tab%0d_pb", i), 32'(fp_pb), 32'(tab[i].pb));
      chk($sformatf("tab%0d_busy", i), 32'(fp_busy), 32'(tab[i].busy));
      if (tab[i].busy) chk($sformatf("tab%0d_id", i), 32'(fp_id), 32'(tab[i].id));
    end
    req = 4'd0; flush = 1'b0; e_tick = 1'b0;

    // Single request from requester 2: hold 8 ticks, gap 4 ticks.
    tick_en = 1'b1;
    do_reset();
    req = 4'b0100; cmd = 24'h005000;
    step();
    req = 4'd0;
    chk("s1_ack_early", 32'(fp_ack), 32'h0);
    step();
    chk("s1_ack", 32'(fp_ack), 32'h4);
    chk("s1_issued", 32'(fp_issued), 32'h4);
    chk("s1_pb", 32'(fp_pb), 32'h05);
    chk("s1_busy", 32'(fp_busy), 32'h1);
    chk("s1_id", 32'(fp_id), 32'h2);
    ticks = 0; extra = 0; timeout = 1'b1;
    for (int k = 0; k < 200; k++) begin
      t = e_tick; step();
      if (t) ticks++;
      if (fp_issued != 4'd0) extra++;
      if (fp_pb != 6'h05) begin timeout = 1'b0; break; end
    end
    chk("s1_hold_timeout", 32'(timeout), 32'h0);
    chk("s1_hold_ticks", 32'(ticks), 32'd8);
    chk("s1_pb_idle", 32'(fp_pb), 32'h3F);
    chk("s1_busy_gap", 32'(fp_busy), 32'h1);
    ticks = 0; timeout = 1'b1;
    for (int k = 0; k < 200; k++) begin
      t = e_tick; step();
      if (t) ticks++;
      if (fp_issued != 4'd0) extra++;
      if (!fp_busy) begin timeout = 1'b0; break; end
    end
    chk("s1_gap_timeout", 32'(timeout), 32'h0);
    chk("s1_gap_ticks", 32'(ticks), 32'd4);
    chk("s1_extra_issue", 32'(extra), 32'd0);

    // Fixed priority: requesters 1 and 3 together.
    do_reset();
    req = 4'b1010; cmd = 24'h4C0440;
    step();
    req = 4'd0;
    step();
    chk("s2_iss1", 32'(fp_issued), 32'h2);
    chk("s2_pb1", 32'(fp_pb), 32'h11);
    chk("s2_id1", 32'(fp_id), 32'h1);
    chk("s2_ack", 32'(fp_ack), 32'hA);
    ticks = 0; timeout = 1'b1;
    for (int k = 0; k < 300; k++) begin
      t = e_tick; step();
      if (t) ticks++;
      if (fp_issued != 4'd0) begin timeout = 1'b0; break; end
    end
    chk("s2_timeout", 32'(timeout), 32'h0);
    chk("s2_iss3", 32'(fp_issued), 32'h8);
    chk("s2_pb3", 32'(fp_pb), 32'h13);
    chk("s2_id3", 32'(fp_id), 32'h3);
    chk("s2_spacing_ticks", 32'(ticks), 32'd12);

    // Round-robin with all four requesting continuously.
    do_reset();
    req = 4'b1111; cmd = {6'h23, 6'h22, 6'h21, 6'h20};
    exp_order = '{0, 1, 2, 3, 0};
    got_order = '{-1, -1, -1, -1, -1};
    n = 0;
    for (int k = 0; k < 600 && n < 5; k++) begin
      step();
      if (rr_issued != 4'd0) begin
        case (rr_issued)
          4'b0001: got_order[n] = 0;
          4'b0010: got_order[n] = 1;
          4'b0100: got_order[n] = 2;
          4'b1000: got_order[n] = 3;
          default: got_order[n] = 9;
        endcase
        n++;
      end
    end
    req = 4'd0;
    for (int i = 0; i < 5; i++) chk($sformatf("s3_rr_order%0d", i), 32'(got_order[i]), 32'(exp_order[i]));

    // Overwrite: requester 0 updates its code while requester 1 is being driven.
    do_reset();
    req = 4'b0010; cmd = 24'h0001C0;
    step();
    req = 4'd0;
    step();
    chk("s4_iss1", 32'(fp_issued), 32'h2);
    repeat (3) step();
    req = 4'b0001; cmd = 24'h000001;
    step();
    req = 4'd0;
    repeat (5) step();
    req = 4'b0001; cmd = 24'h000002;
    step();
    req = 4'd0;
    timeout = 1'b1;
    for (int k = 0; k < 300; k++) begin
      step();
      if (fp_issued != 4'd0) begin timeout = 1'b0; break; end
    end
    chk("s4_timeout", 32'(timeout), 32'h0);
    chk("s4_iss0", 32'(fp_issued), 32'h1);
    chk("s4_pb0", 32'(fp_pb), 32'h02);
    repeat (80) step();
    chk("s4_ack0_count", 32'(ack0_cnt), 32'd2);
    chk("s4_iss0_count", 32'(iss0_cnt), 32'd1);
    chk("s4_old_code_seen", 32'(seen01), 32'd0);

    // Zero gap: back-to-back commands separated by one idle cycle.
    do_reset();
    req = 4'b0011; cmd = 24'h0002CA;
    step();
    req = 4'd0;
    step();
    chk("s5_iss0", 32'(g0_issued), 32'h1);
    chk("s5_pb0", 32'(g0_pb), 32'h0A);
    ticks = 0; gapc = 0; timeout = 1'b1;
    for (int k = 0; k < 300; k++) begin
      t = e_tick; step();
      if (t) ticks++;
      if (g0_pb == 6'h3F) gapc++;
      if (g0_issued != 4'd0) begin timeout = 1'b0; break; end
    end
    chk("s5_timeout", 32'(timeout), 32'h0);
    chk("s5_iss1", 32'(g0_issued), 32'h2);
    chk("s5_pb1", 32'(g0_pb), 32'h0B);
    chk("s5_gap_cycles", 32'(gapc), 32'd1);
    chk("s5_hold_ticks", 32'(ticks), 32'd8);

    // Flush mid-DRIVE with two slots still pending; the request in the flush cycle is dropped.
    do_reset();
    req = 4'b0111; cmd = 24'h003081;
    step();
    req = 4'd0;
    step();
    chk("s6_iss0", 32'(fp_issued), 32'h1);
    repeat (5) step();
    flush = 1'b1; req = 4'b1000; cmd = 24'hA80000;
    step();
    flush = 1'b0; req = 4'd0;
    chk("s6_pb", 32'(fp_pb), 32'h3F);
    chk("s6_busy", 32'(fp_busy), 32'h0);
    iss_cnt = 0; extra = 0;
    step();
    chk("s6_ack_suppressed", 32'(fp_ack), 32'h0);
    for (int k = 0; k < 80; k++) begin
      step();
      if (fp_busy) extra++;
    end
    chk("s6_no_issue", 32'(iss_cnt), 32'd0);
    chk("s6_stays_idle", 32'(extra), 32'd0);

    // Reset mid-DRIVE with two slots still pending.
    do_reset();
    req = 4'b0111; cmd = 24'h003081;
    step();
    req = 4'd0;
    step();
    chk("s7_iss0", 32'(fp_issued), 32'h1);
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("s7_pb", 32'(fp_pb), 32'h3F);
    chk("s7_busy", 32'(fp_busy), 32'h0);
    iss_cnt = 0;
    repeat (80) step();
    chk("s7_no_issue", 32'(iss_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
